register_file_mp: RTL and testbench

- Parametrised successor to the single-write, two-read register file.
- Configurable data width, register count, read-port count and write-port count.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a per-register pending scoreboard: issue logic allocates destinations and writeback clears them. The core pipeline uses it for multi-issue decode/writeback and hazard detection.

---
 rtl/register_file_mp.sv | 109 ++++++++++
 tb/tb_register_file_mp.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file with a
// per-register pending scoreboard, optional x0 and write-to-read bypass.
// Ports:
//   clk, reset (async, active low)
//   wr_en/wr_addr/wr_data : NWR packed write ports
//   rd_addr/rd_data/rd_busy : NRD packed read ports
//   alloc_en/alloc_addr : mark a destination pending
//   busy : registered pending-bit vector
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_nxt;

  // Register 0 is a constant when ZERO_REG is set.
  function automatic logic f_live(
    input logic [AW-1:0] a
  );
    return !(ZERO_REG && (a == '0));
  endfunction

  // Writes retire their producer; a same-cycle
  // allocation re-arms the bit afterwards.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) begin
        w_pend_nxt[wr_addr[k*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en && f_live(alloc_addr)) begin
      w_pend_nxt[alloc_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      w_pend_nxt[0] = 1'b0;
    end
  end

  // Ascending port order: the highest port's
  // non-blocking update lands last and wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pend <= w_pend_nxt;
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] &&
            f_live(wr_addr[k*AW +: AW])) begin
          r_regs[wr_addr[k*AW +: AW]] <=
            wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin : g_rd
      logic [AW-1:0]   w_a;
      logic [XLEN-1:0] w_d;
      logic            w_b;
      w_a = rd_addr[j*AW +: AW];
      w_d = r_regs[w_a];
      w_b = r_pend[w_a];
      if (BYPASS && reset) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] &&
              (wr_addr[k*AW +: AW] == w_a)) begin
            w_d = wr_data[k*XLEN +: XLEN];
            w_b = 1'b0;
          end
        end
      end
      if (!f_live(w_a) || !reset) begin
        w_d = '0;
        w_b = 1'b0;
      end
      rd_data[j*XLEN +: XLEN] = w_d;
      rd_busy[j] = w_b;
    end
  end

  assign busy = r_pend;

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: three register_file_mp configurations driven by
// directed vectors, checked each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_register_file_mp;

  logic clk;
  logic reset;

  // Generic stimulus, one slot per instance.
  logic [1:0]  t_wen [3];
  logic [5:0]  t_wa  [3][2];
  logic [63:0] t_wd  [3][2];
  logic [5:0]  t_ra  [3][3];
  logic        t_aen [3];
  logic [5:0]  t_aa  [3];

  // Model state.
  logic [63:0] m_reg  [3][64];
  logic        m_pend [3][64];

  int n_vec;
  int n_bad;

  // u0: 32x32, 2 read, 2 write, bypass
  logic [1:0]   u0_wr_en;
  logic [9:0]   u0_wr_addr;
  logic [63:0]  u0_wr_data;
  logic [9:0]   u0_rd_addr;
  logic [63:0]  u0_rd_data;
  logic [1:0]   u0_rd_busy;
  logic [31:0]  u0_busy;
  // u1: 32x32, 2 read, 1 write, no bypass
  logic         u1_wr_en;
  logic [4:0]   u1_wr_addr;
  logic [31:0]  u1_wr_data;
  logic [9:0]   u1_rd_addr;
  logic [63:0]  u1_rd_data;
  logic [1:0]   u1_rd_busy;
  logic [31:0]  u1_busy;
  // u2: 64x64, 3 read, 1 write, bypass
  logic         u2_wr_en;
  logic [5:0]   u2_wr_addr;
  logic [63:0]  u2_wr_data;
  logic [17:0]  u2_rd_addr;
  logic [191:0] u2_rd_data;
  logic [2:0]   u2_rd_busy;
  logic [63:0]  u2_busy;

  assign u0_wr_en   = t_wen[0];
  assign u0_wr_addr = {t_wa[0][1][4:0], t_wa[0][0][4:0]};
  assign u0_wr_data = {t_wd[0][1][31:0], t_wd[0][0][31:0]};
  assign u0_rd_addr = {t_ra[0][1][4:0], t_ra[0][0][4:0]};
  assign u1_wr_en   = t_wen[1][0];
  assign u1_wr_addr = t_wa[1][0][4:0];
  assign u1_wr_data = t_wd[1][0][31:0];
  assign u1_rd_addr = {t_ra[1][1][4:0], t_ra[1][0][4:0]};
  assign u2_wr_en   = t_wen[2][0];
  assign u2_wr_addr = t_wa[2][0];
  assign u2_wr_data = t_wd[2][0];
  assign u2_rd_addr = {t_ra[2][2], t_ra[2][1], t_ra[2][0]};

  register_file_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u0 (
    .clk(clk), .reset(reset),
    .wr_en(u0_wr_en), .wr_addr(u0_wr_addr),
    .wr_data(u0_wr_data), .rd_addr(u0_rd_addr),
    .rd_data(u0_rd_data), .rd_busy(u0_rd_busy),
    .alloc_en(t_aen[0]), .alloc_addr(t_aa[0][4:0]),
    .busy(u0_busy)
  );

  register_file_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(1),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) u1 (
    .clk(clk), .reset(reset),
    .wr_en(u1_wr_en), .wr_addr(u1_wr_addr),
    .wr_data(u1_wr_data), .rd_addr(u1_rd_addr),
    .rd_data(u1_rd_data), .rd_busy(u1_rd_busy),
    .alloc_en(t_aen[1]), .alloc_addr(t_aa[1][4:0]),
    .busy(u1_busy)
  );

  register_file_mp #(
    .XLEN(64), .NREGS(64), .NRD(3), .NWR(1),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u2 (
    .clk(clk), .reset(reset),
    .wr_en(u2_wr_en), .wr_addr(u2_wr_addr),
    .wr_data(u2_wr_data), .rd_addr(u2_rd_addr),
    .rd_data(u2_rd_data), .rd_busy(u2_rd_busy),
    .alloc_en(t_aen[2]), .alloc_addr(t_aa[2]),
    .busy(u2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance configuration.
  function automatic int nr(input int i);
    return (i == 2) ? 64 : 32;
  endfunction
  function automatic int nrd(input int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int nwr(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic bit bp(input int i);
    return (i != 1);
  endfunction
  function automatic logic [63:0] dmask(input int i);
    return (i == 2) ? 64'hFFFF_FFFF_FFFF_FFFF
                    : 64'h0000_0000_FFFF_FFFF;
  endfunction
  function automatic logic [5:0] amask(input int i);
    return (i == 2) ? 6'h3F : 6'h1F;
  endfunction

  function automatic logic [63:0] get_rd(input int i, input int j);
    case (i)
      0:       return {32'h0, u0_rd_data[j*32 +: 32]};
      1:       return {32'h0, u1_rd_data[j*32 +: 32]};
      default: return u2_rd_data[j*64 +: 64];
    endcase
  endfunction
  function automatic logic get_rb(input int i, input int j);
    case (i)
      0:       return u0_rd_busy[j];
      1:       return u1_rd_busy[j];
      default: return u2_rd_busy[j];
    endcase
  endfunction
  function automatic logic [63:0] get_busy(input int i);
    case (i)
      0:       return {32'h0, u0_busy};
      1:       return {32'h0, u1_busy};
      default: return u2_busy;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < 64; r++) begin
        m_reg[i][r]  = '0;
        m_pend[i][r] = 1'b0;
      end
  endtask

  // Edge semantics: later ports overwrite earlier ones, writes retire
  // pending bits, then an allocation marks its target pending.
  task automatic model_edge();
    logic [5:0] a;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < nwr(i); k++) begin
          if (t_wen[i][k]) begin
            a = t_wa[i][k] & amask(i);
            if (a != 0) m_reg[i][a] = t_wd[i][k] & dmask(i);
            m_pend[i][a] = 1'b0;
          end
        end
        a = t_aa[i] & amask(i);
        if (t_aen[i] && a != 0) m_pend[i][a] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [5:0]  a;
    logic [63:0] ed;
    logic        eb;
    logic [63:0] ev;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < nrd(i); j++) begin
        a  = t_ra[i][j] & amask(i);
        ed = '0;
        eb = 1'b0;
        if (reset && a != 0) begin
          ed = m_reg[i][a];
          eb = m_pend[i][a];
          if (bp(i)) begin
            for (int k = 0; k < nwr(i); k++) begin
              if (t_wen[i][k] && ((t_wa[i][k] & amask(i)) == a)) begin
                ed = t_wd[i][k] & dmask(i);
                eb = 1'b0;
              end
            end
          end
        end
        cmp($sformatf("rd_data u%0d p%0d a%0d", i, j, a),
            get_rd(i, j), ed);
        cmp($sformatf("rd_busy u%0d p%0d a%0d", i, j, a),
            {63'h0, get_rb(i, j)}, {63'h0, eb});
      end
      ev = '0;
      for (int r = 0; r < nr(i); r++) ev[r] = reset & m_pend[i][r];
      cmp($sformatf("busy u%0d", i), get_busy(i), ev);
    end
  endtask

  always @(negedge clk) check_all();

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      t_wen[i] = '0;
      t_aen[i] = 1'b0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_wen[i] = '0;
      t_aen[i] = 1'b0;
      t_aa[i]  = '0;
      for (int k = 0; k < 2; k++) begin
        t_wa[i][k] = '0;
        t_wd[i][k] = '0;
      end
      for (int j = 0; j < 3; j++) t_ra[i][j] = '0;
    end
    model_clear();

    // 1: reset, defaults, x0
    cyc();
    cyc();
    reset = 1'b1;
    t_ra[0][0] = 6'd5;
    t_ra[0][1] = 6'd31;
    #1;
    cmp("t1 rd5", get_rd(0, 0), 64'h0);
    cmp("t1 rd31", get_rd(0, 1), 64'h0);
    cmp("t1 busy", get_busy(0), 64'h0);
    t_wen[0]   = 2'b01;
    t_wa[0][0] = 6'd0;
    t_wd[0][0] = 64'hDEADBEEF;
    t_ra[0][0] = 6'd0;
    #1;
    cmp("t1 x0 same", get_rd(0, 0), 64'h0);
    cyc();
    idle();
    #1;
    cmp("t1 x0 next", get_rd(0, 0), 64'h0);

    // 2: bypass on u0, no bypass on u1
    t_wen[0]   = 2'b01;
    t_wa[0][0] = 6'd3;
    t_wd[0][0] = 64'h12345678;
    t_ra[0][0] = 6'd3;
    t_wen[1]   = 2'b01;
    t_wa[1][0] = 6'd3;
    t_wd[1][0] = 64'h12345678;
    t_ra[1][0] = 6'd3;
    #1;
    cmp("t2 byp same", get_rd(0, 0), 64'h12345678);
    cmp("t2 nobyp old", get_rd(1, 0), 64'h0);
    cyc();
    idle();
    #1;
    cmp("t2 byp after", get_rd(0, 0), 64'h12345678);
    cmp("t2 nobyp after", get_rd(1, 0), 64'h12345678);

    // 3: dual write to one address
    t_wen[0]   = 2'b11;
    t_wa[0][0] = 6'd7;
    t_wd[0][0] = 64'hAAAA0000;
    t_wa[0][1] = 6'd7;
    t_wd[0][1] = 64'h0000BBBB;
    t_ra[0][0] = 6'd7;
    #1;
    cmp("t3 byp hi", get_rd(0, 0), 64'h0000BBBB);
    cyc();
    idle();
    #1;
    cmp("t3 reg hi", get_rd(0, 0), 64'h0000BBBB);

    // 4: scoreboard, u0 and u1 in lockstep
    for (int i = 0; i < 2; i++) begin
      t_aen[i]   = 1'b1;
      t_aa[i]    = 6'd9;
      t_ra[i][1] = 6'd9;
    end
    cyc();
    idle();
    #1;
    cmp("t4 busy n+1", {63'h0, u0_busy[9]}, 64'h1);
    cmp("t4 rdb n+1", {63'h0, get_rb(0, 1)}, 64'h1);
    cyc();
    #1;
    cmp("t4 busy n+2", {63'h0, u0_busy[9]}, 64'h1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      t_wen[i]   = 2'b01;
      t_wa[i][0] = 6'd9;
      t_wd[i][0] = 64'h55;
    end
    #1;
    cmp("t4 busy n+3", {63'h0, u0_busy[9]}, 64'h1);
    cmp("t4 rdb byp", {63'h0, get_rb(0, 1)}, 64'h0);
    cmp("t4 rdb nobyp", {63'h0, get_rb(1, 1)}, 64'h1);
    cyc();
    idle();
    #1;
    cmp("t4 busy n+4", {63'h0, u0_busy[9]}, 64'h0);
    cmp("t4 rd 55", get_rd(0, 1), 64'h55);
    for (int i = 0; i < 2; i++) begin
      t_aen[i]   = 1'b1;
      t_aa[i]    = 6'd9;
      t_wen[i]   = 2'b01;
      t_wa[i][0] = 6'd9;
      t_wd[i][0] = 64'h66;
    end
    cyc();
    idle();
    #1;
    cmp("t4 rd 66", get_rd(0, 1), 64'h66);
    cmp("t4 busy re", {63'h0, u0_busy[9]}, 64'h1);

    // 5: fill, then asynchronous reset pulse
    for (int r = 1; r < 32; r++) begin
      t_wen[0]   = 2'b01;
      t_wa[0][0] = 6'(r);
      t_wd[0][0] = 64'(r + 32'h1000);
      cyc();
    end
    idle();
    t_aen[0] = 1'b1;
    t_aa[0]  = 6'd4;
    cyc();
    idle();
    t_ra[0][0] = 6'd5;
    t_ra[0][1] = 6'd4;
    #1;
    cmp("t5 pre rd5", get_rd(0, 0), 64'h1005);
    cmp("t5 pre b4", {63'h0, u0_busy[4]}, 64'h1);
    cyc();
    reset = 1'b0;
    model_clear();
    #1;
    cmp("t5 rst rd5", get_rd(0, 0), 64'h0);
    cmp("t5 rst rd4", get_rd(0, 1), 64'h0);
    cmp("t5 rst busy", get_busy(0), 64'h0);
    cmp("t5 rst rdb", {63'h0, get_rb(0, 1)}, 64'h0);
    #2;
    reset      = 1'b1;
    t_wen[0]   = 2'b01;
    t_wa[0][0] = 6'd10;
    t_wd[0][0] = 64'hBEEF;
    cyc();
    idle();
    t_ra[0][0] = 6'd10;
    #1;
    cmp("t5 post w10", get_rd(0, 0), 64'hBEEF);
    cmp("t5 post rd4", get_rd(0, 1), 64'h0);

    // 6: 64x64 sweep on u2
    for (int r = 0; r < 64; r++) begin
      logic [31:0] iv;
      iv = 32'(r);
      t_wen[2]   = 2'b01;
      t_wa[2][0] = 6'(r);
      t_wd[2][0] = {32'hC0DE0000 | iv, ~iv};
      t_ra[2][0] = 6'(r);
      cyc();
    end
    idle();
    for (int r = 0; r < 64; r++) begin
      t_ra[2][0] = 6'(r);
      t_ra[2][1] = 6'((r + 1) % 64);
      t_ra[2][2] = 6'((r + 2) % 64);
      #1;
      if (r == 0) cmp("t6 x0", get_rd(2, 0), 64'h0);
      if (r == 5) cmp("t6 r5", get_rd(2, 0), 64'hC0DE0005_FFFFFFFA);
      if (r == 62) cmp("t6 r63", get_rd(2, 1), 64'hC0DE003F_FFFFFFC0);
      cyc();
    end

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
